csr_file_v2: RTL

//  Parametrised M-mode CSR file, successor of the fixed single-port CSR block. Serves EXU

---
 rtl/csr_file_v2_if.sv | 21 ++
 rtl/csr_file_v2.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/csr_file_v2_if.sv
// rtl/csr_file_v2_if.sv - EXU-side Zicsr access bus into the CSR file
interface csr_file_v2_if #(
  parameter int XLEN = 32
);
  logic            exu_en_i;
  logic [1:0]      exu_op_i;
  logic [11:0]     exu_addr_i;
  logic [XLEN-1:0] exu_wdata_i;
  logic [XLEN-1:0] exu_rdata_o;
  logic            exu_illegal_o;

  modport master (
    output exu_en_i, exu_op_i, exu_addr_i, exu_wdata_i,
    input  exu_rdata_o, exu_illegal_o
  );

  modport slave (
    input  exu_en_i, exu_op_i, exu_addr_i, exu_wdata_i,
    output exu_rdata_o, exu_illegal_o
  );
endinterface

// File: rtl/csr_file_v2.sv
// rtl/csr_file_v2.sv - M-mode CSR file: Zicsr RW/RS/RC, trap/MRET stacking, cycle/instret/HPM counters
module csr_file_v2 #(
  parameter int          XLEN      = 32,
  parameter int          CNT_W     = 64,
  parameter int          NUM_HPM   = 4,
  parameter logic [31:0] MTVEC_RST = 32'h0,
  parameter logic [31:0] HART_ID   = 32'h0
) (
  input  logic               clk,
  input  logic               rstn,
  csr_file_v2_if.slave       exu,
  input  logic               instret_i,
  input  logic [NUM_HPM-1:0] hpm_evt_i,
  input  logic               trap_i,
  input  logic [XLEN-1:0]    trap_cause_i,
  input  logic [XLEN-1:0]    trap_pc_i,
  input  logic [XLEN-1:0]    trap_val_i,
  input  logic               mret_i,
  input  logic [2:0]         irq_i,
  output logic [XLEN-1:0]    mtvec_o,
  output logic [XLEN-1:0]    mepc_o,
  output logic               irq_pend_o
);

  // Counter index 0 = mcycle, 1 = minstret, 2.. = mhpmcounter3..
  localparam int NCNT = 2 + NUM_HPM;
  localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

  function automatic logic [31:0] inh_mask_f();
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int n = 0; n < NUM_HPM; n++) m[3+n] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] INH_MASK = inh_mask_f();

  function automatic logic [11:0] cnt_addr(input int idx, input logic [11:0] base);
    return base + ((idx == 0) ? 12'h000 : 12'(idx + 1));
  endfunction

  logic             mst_mie, mst_mpie;
  logic [31:0]      mie_q, mip_q, mtvec_q, mepc_q, mcause_q, mtval_q, mscratch_q, minh_q;
  logic [CNT_W-1:0] cnt_q  [NCNT];
  logic [63:0]      cnt_x  [NCNT];
  logic [63:0]      cnt_nx [NCNT];
  logic [NCNT-1:0]  cnt_run, cnt_wr_lo, cnt_wr_hi;
  logic [31:0]      mstatus_rd, mtvec_rd, mepc_rd, rval, nval;
  logic             hit, write_try, illegal, exu_wr;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
  assign mtvec_rd   = {mtvec_q[31:2], 1'b0, mtvec_q[0]};
  assign mepc_rd    = {mepc_q[31:2], 2'b00};

  always_comb begin
    for (int i = 0; i < NCNT; i++) cnt_x[i] = 64'(cnt_q[i]);
  end

  // Address decode; the counter lo/hi select also steers the write path
  always_comb begin
    hit       = 1'b1;
    rval      = '0;
    cnt_wr_lo = '0;
    cnt_wr_hi = '0;
    case (exu.exu_addr_i)
      12'h300: rval = mstatus_rd;
      12'h304: rval = mie_q;
      12'h305: rval = mtvec_rd;
      12'h320: rval = minh_q;
      12'h340: rval = mscratch_q;
      12'h341: rval = mepc_rd;
      12'h342: rval = mcause_q;
      12'h343: rval = mtval_q;
      12'h344: rval = mip_q;
      12'hF14: rval = HART_ID;
      default: hit = 1'b0;
    endcase
    for (int i = 0; i < NCNT; i++) begin
      if (exu.exu_addr_i == cnt_addr(i, 12'hB00)) begin
        hit          = 1'b1;
        rval         = cnt_x[i][31:0];
        cnt_wr_lo[i] = 1'b1;
      end
      if (exu.exu_addr_i == cnt_addr(i, 12'hB80)) begin
        hit          = 1'b1;
        rval         = cnt_x[i][63:32];
        cnt_wr_hi[i] = 1'b1;
      end
      if (i < 2 && exu.exu_addr_i == cnt_addr(i, 12'hC00)) begin
        hit  = 1'b1;
        rval = cnt_x[i][31:0];
      end
      if (i < 2 && exu.exu_addr_i == cnt_addr(i, 12'hC80)) begin
        hit  = 1'b1;
        rval = cnt_x[i][63:32];
      end
    end
  end

  // RS/RC with a zero operand is a pure read, so it stays legal on read-only CSRs
  assign write_try = (exu.exu_op_i != 2'b00) &&
                     ((exu.exu_op_i == 2'b01) || (exu.exu_wdata_i != '0));
  assign illegal   = exu.exu_en_i &&
                     (!hit || ((exu.exu_addr_i[11:10] == 2'b11) && write_try));
  assign exu_wr    = exu.exu_en_i && write_try && !illegal && !trap_i && !mret_i;

  assign exu.exu_illegal_o = illegal;
  assign exu.exu_rdata_o   = illegal ? '0 : rval;

  always_comb begin
    case (exu.exu_op_i)
      2'b01:   nval = exu.exu_wdata_i;
      2'b10:   nval = rval | exu.exu_wdata_i;
      2'b11:   nval = rval & ~exu.exu_wdata_i;
      default: nval = rval;
    endcase
  end

  assign cnt_run = {hpm_evt_i, instret_i, 1'b1} &
                   ~{minh_q[3 +: NUM_HPM], minh_q[2], minh_q[0]};

  // A half-write freezes the other half for that cycle: no increment, no carry
  always_comb begin
    for (int i = 0; i < NCNT; i++) begin
      cnt_nx[i] = cnt_x[i];
      if (exu_wr && cnt_wr_lo[i]) begin
        cnt_nx[i][31:0] = nval;
      end else if (exu_wr && cnt_wr_hi[i]) begin
        cnt_nx[i][63:32] = nval;
      end else if (cnt_run[i]) begin
        cnt_nx[i] = cnt_x[i] + 64'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= MTVEC_RST & ~32'h0000_0002;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mscratch_q <= '0;
      minh_q     <= '0;
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
    end else begin
      mip_q <= {20'b0, irq_i[2], 3'b0, irq_i[1], 3'b0, irq_i[0], 3'b0};
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= cnt_nx[i][CNT_W-1:0];
      if (trap_i) begin
        mepc_q   <= trap_pc_i;
        mcause_q <= trap_cause_i;
        mtval_q  <= trap_val_i;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (mret_i) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (exu_wr) begin
        case (exu.exu_addr_i)
          12'h300: begin
            mst_mie  <= nval[3];
            mst_mpie <= nval[7];
          end
          12'h304: mie_q      <= nval & IRQ_MASK;
          12'h305: mtvec_q    <= nval;
          12'h320: minh_q     <= nval & INH_MASK;
          12'h340: mscratch_q <= nval;
          12'h341: mepc_q     <= nval;
          12'h342: mcause_q   <= nval;
          12'h343: mtval_q    <= nval;
          default: ;
        endcase
      end
    end
  end

  assign mtvec_o    = mtvec_rd;
  assign mepc_o     = mepc_rd;
  assign irq_pend_o = mst_mie & |(mip_q & mie_q);

endmodule
